// File: rtl/pc_sequencer.sv
// Fetch PC owner for the 5-stage MIPS32 pipeline: sequential fetch, branch/jump
// redirects with optional delay slot, exception redirects, and a one-deep redirect buffer.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter int unsigned DELAY_SLOT = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_id,
   input  logic             imem_ready,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   input  logic             exc_valid,
   input  logic [31:0]      exc_pc,
   output logic [31:0]      pc,
   output logic [31:0]      pc_4,
   output logic             fetch_valid,
   output logic             flush_if,
   output logic             redirect_pending,
   output logic             redirect_overrun,
   output logic             pc_misaligned,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam bit HAS_DS = (DELAY_SLOT != 0);

   typedef enum logic {ST_RUN, ST_PEND} state_t;

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_pc, w_pc_nxt;
   logic [31:0]      r_pend_pc, w_pend_nxt;
   logic             r_fetch_valid;
   logic             r_overrun;
   logic [CNT_W-1:0] r_cnt;
   logic             w_adv;
   logic             w_load_redirect;
   logic             w_overrun_set;

   assign w_adv = r_fetch_valid & imem_ready & ~stall_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_pc          <= RESET_PC;
         r_pend_pc     <= '0;
         r_fetch_valid <= 1'b0;
         r_overrun     <= 1'b0;
         r_cnt         <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_pend_pc     <= w_pend_nxt;
         r_fetch_valid <= 1'b1;
         if (w_overrun_set)
            r_overrun <= 1'b1;
         if (w_load_redirect && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
      end
   end

   // Priority: exception > redirect (buffered or new) > sequential advance.
   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_pend_nxt      = r_pend_pc;
      w_load_redirect = 1'b0;
      w_overrun_set   = 1'b0;
      if (exc_valid) begin
         w_pc_nxt    = exc_pc;
         w_state_nxt = ST_RUN;
         w_pend_nxt  = '0;
      end else if (r_state == ST_PEND) begin
         w_overrun_set = redirect_valid;
         if (w_adv) begin
            w_pc_nxt        = r_pend_pc;
            w_state_nxt     = ST_RUN;
            w_load_redirect = 1'b1;
         end
      end else if (redirect_valid) begin
         if (!HAS_DS || w_adv) begin
            w_pc_nxt        = redirect_pc;
            w_load_redirect = 1'b1;
         end else begin
            w_pend_nxt  = redirect_pc;
            w_state_nxt = ST_PEND;
         end
      end else if (w_adv) begin
         w_pc_nxt = r_pc + 32'd4;
      end
   end

   always_comb begin
      pc               = r_pc;
      pc_4             = r_pc + 32'd4;
      fetch_valid      = r_fetch_valid;
      redirect_pending = (r_state == ST_PEND);
      redirect_overrun = r_overrun;
      pc_misaligned    = |r_pc[1:0];
      redirect_cnt     = r_cnt;
      // Without a delay slot the instruction already fetched after the branch must die.
      flush_if         = ~rst & (exc_valid |
                         (!HAS_DS & redirect_valid & (r_state == ST_RUN)));
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a delay-slot build and a no-delay-slot build
// with a narrow counter, both driven from the same stimulus.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_id, imem_ready, redirect_valid, exc_valid;
   logic [31:0] redirect_pc, exc_pc;

   logic [31:0] pc, pc_4;
   logic        fetch_valid, flush_if, redirect_pending, redirect_overrun, pc_misaligned;
   logic [15:0] redirect_cnt;

   logic [31:0] pc0, pc0_4;
   logic        fv0, flush0, pend0, ovr0, mis0;
   logic [1:0]  cnt0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .stall_id(stall_id), .imem_ready(imem_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .exc_valid(exc_valid), .exc_pc(exc_pc),
      .pc(pc), .pc_4(pc_4), .fetch_valid(fetch_valid), .flush_if(flush_if),
      .redirect_pending(redirect_pending), .redirect_overrun(redirect_overrun),
      .pc_misaligned(pc_misaligned), .redirect_cnt(redirect_cnt)
   );

   pc_sequencer #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(0), .CNT_W(2)) dut0 (
      .clk(clk), .rst(rst), .stall_id(stall_id), .imem_ready(imem_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .exc_valid(exc_valid), .exc_pc(exc_pc),
      .pc(pc0), .pc_4(pc0_4), .fetch_valid(fv0), .flush_if(flush0),
      .redirect_pending(pend0), .redirect_overrun(ovr0),
      .pc_misaligned(mis0), .redirect_cnt(cnt0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall_id = 1'b0; imem_ready = 1'b0; redirect_valid = 1'b0;
      exc_valid = 1'b0; redirect_pc = '0; exc_pc = '0;
      tick(); tick();
      n_checks++; if (pc !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
      n_checks++; if (pc_4 !== 32'h3004) begin n_fail++; $display("FAIL reset_pc4 got=%h exp=%h", pc_4, 32'h3004); end
      n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got=%b exp=0", fetch_valid); end
      n_checks++; if (flush_if !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", flush_if); end
      n_checks++; if (redirect_pending !== 1'b0 || redirect_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_pend_ovr got=%b%b exp=00", redirect_pending, redirect_overrun); end
      n_checks++; if (redirect_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", redirect_cnt); end
      rst = 1'b0; imem_ready = 1'b1;
      tick();
      n_checks++; if (fetch_valid !== 1'b1 || pc !== 32'h3000) begin n_fail++; $display("FAIL release_fv got fv=%b pc=%h exp fv=1 pc=00003000", fetch_valid, pc); end
      repeat (4) tick();
      n_checks++; if (pc !== 32'h3010) begin n_fail++; $display("FAIL run_to_3010 got=%h exp=%h", pc, 32'h3010); end
      rst = 1'b1;
      #1;
      n_checks++; if (pc !== 32'h3000 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset got pc=%h fv=%b exp pc=00003000 fv=0", pc, fetch_valid); end
      tick();
      rst = 1'b0;
      tick();
      n_checks++; if (fetch_valid !== 1'b1 || pc !== 32'h3000) begin n_fail++; $display("FAIL rerelease got fv=%b pc=%h exp fv=1 pc=00003000", fetch_valid, pc); end
   endtask

   task automatic test_seq_stall();
      tick();
      n_checks++; if (pc !== 32'h3004) begin n_fail++; $display("FAIL seq_3004 got=%h exp=%h", pc, 32'h3004); end
      stall_id = 1'b1;
      tick();
      n_checks++; if (pc !== 32'h3004) begin n_fail++; $display("FAIL stall1 got=%h exp=%h", pc, 32'h3004); end
      tick();
      n_checks++; if (pc !== 32'h3004) begin n_fail++; $display("FAIL stall2 got=%h exp=%h", pc, 32'h3004); end
      stall_id = 1'b0;
      tick();
      n_checks++; if (pc !== 32'h3008) begin n_fail++; $display("FAIL seq_3008 got=%h exp=%h", pc, 32'h3008); end
   endtask

   task automatic test_delay_slot_overrun();
      imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h3100;
      #1;
      n_checks++; if (flush_if !== 1'b0) begin n_fail++; $display("FAIL ds_flush got=%b exp=0", flush_if); end
      tick();
      n_checks++; if (redirect_pending !== 1'b1 || pc !== 32'h3008) begin n_fail++; $display("FAIL ds_capture got pend=%b pc=%h exp pend=1 pc=00003008", redirect_pending, pc); end
      redirect_pc = 32'h3200;
      tick();
      redirect_valid = 1'b0;
      n_checks++; if (redirect_overrun !== 1'b1 || redirect_pending !== 1'b1) begin n_fail++; $display("FAIL overrun got ovr=%b pend=%b exp 1 1", redirect_overrun, redirect_pending); end
      tick();
      n_checks++; if (pc !== 32'h3008 || redirect_cnt !== 16'd0) begin n_fail++; $display("FAIL ds_hold got pc=%h cnt=%0d exp pc=00003008 cnt=0", pc, redirect_cnt); end
      imem_ready = 1'b1;
      tick();
      n_checks++; if (pc !== 32'h3100) begin n_fail++; $display("FAIL ds_apply got=%h exp=%h", pc, 32'h3100); end
      n_checks++; if (redirect_pending !== 1'b0 || redirect_cnt !== 16'd1 || redirect_overrun !== 1'b1) begin n_fail++; $display("FAIL ds_after got pend=%b cnt=%0d ovr=%b exp 0 1 1", redirect_pending, redirect_cnt, redirect_overrun); end
   endtask

   task automatic test_exc_priority();
      imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h3300;
      tick();
      n_checks++; if (redirect_pending !== 1'b1) begin n_fail++; $display("FAIL exc_setup_pend got=%b exp=1", redirect_pending); end
      redirect_pc = 32'h3400; exc_valid = 1'b1; exc_pc = 32'h4180;
      #1;
      n_checks++; if (flush_if !== 1'b1) begin n_fail++; $display("FAIL exc_flush got=%b exp=1", flush_if); end
      tick();
      exc_valid = 1'b0; redirect_valid = 1'b0;
      n_checks++; if (pc !== 32'h4180 || redirect_pending !== 1'b0) begin n_fail++; $display("FAIL exc_load got pc=%h pend=%b exp pc=00004180 pend=0", pc, redirect_pending); end
      n_checks++; if (redirect_cnt !== 16'd1) begin n_fail++; $display("FAIL exc_cnt got=%0d exp=1", redirect_cnt); end
      imem_ready = 1'b1;
      tick();
      n_checks++; if (pc !== 32'h4184) begin n_fail++; $display("FAIL exc_discard got=%h exp=%h", pc, 32'h4184); end
   endtask

   task automatic test_wrap_misalign();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      n_checks++; if (pc !== 32'hFFFF_FFFC || redirect_cnt !== 16'd2) begin n_fail++; $display("FAIL wrap_load got pc=%h cnt=%0d exp pc=fffffffc cnt=2", pc, redirect_cnt); end
      n_checks++; if (pc_4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got=%h exp=00000000", pc_4); end
      tick();
      n_checks++; if (pc !== 32'h0 || pc_misaligned !== 1'b0) begin n_fail++; $display("FAIL wrap got pc=%h mis=%b exp pc=00000000 mis=0", pc, pc_misaligned); end
      redirect_valid = 1'b1; redirect_pc = 32'h3002;
      tick();
      redirect_valid = 1'b0;
      n_checks++; if (pc !== 32'h3002 || pc_misaligned !== 1'b1) begin n_fail++; $display("FAIL misalign got pc=%h mis=%b exp pc=00003002 mis=1", pc, pc_misaligned); end
      n_checks++; if (redirect_cnt !== 16'd3) begin n_fail++; $display("FAIL misalign_cnt got=%0d exp=3", redirect_cnt); end
   endtask

   task automatic test_no_delay_slot();
      rst = 1'b1;
      #1;
      n_checks++; if (redirect_cnt !== 16'd0 || redirect_overrun !== 1'b0) begin n_fail++; $display("FAIL midrun_reset got cnt=%0d ovr=%b exp 0 0", redirect_cnt, redirect_overrun); end
      tick();
      rst = 1'b0; imem_ready = 1'b1;
      tick(); tick();
      n_checks++; if (pc0 !== 32'h3004) begin n_fail++; $display("FAIL nds_start got=%h exp=%h", pc0, 32'h3004); end
      imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h3040;
      #1;
      n_checks++; if (flush0 !== 1'b1 || flush_if !== 1'b0) begin n_fail++; $display("FAIL nds_flush got ds0=%b ds1=%b exp ds0=1 ds1=0", flush0, flush_if); end
      tick();
      n_checks++; if (pc0 !== 32'h3040 || pend0 !== 1'b0 || cnt0 !== 2'd1) begin n_fail++; $display("FAIL nds_apply got pc=%h pend=%b cnt=%0d exp 00003040 0 1", pc0, pend0, cnt0); end
      n_checks++; if (pc !== 32'h3004 || redirect_pending !== 1'b1) begin n_fail++; $display("FAIL ds1_parallel got pc=%h pend=%b exp 00003004 1", pc, redirect_pending); end
      redirect_pc = 32'h3080;
      tick(); tick(); tick();
      redirect_valid = 1'b0;
      n_checks++; if (pc0 !== 32'h3080 || cnt0 !== 2'd3) begin n_fail++; $display("FAIL nds_saturate got pc=%h cnt=%0d exp 00003080 3", pc0, cnt0); end
   endtask

   initial begin
      test_reset();
      test_seq_stall();
      test_delay_slot_overrun();
      test_exc_priority();
      test_wrap_misalign();
      test_no_delay_slot();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
